// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down counter.
// Counts modulo MAX+1 (wrap) or clamps at 0/MAX (saturate), with a
// synchronous clear and load, a combinational terminal-count flag, a
// one-cycle wrap pulse and a sticky overflow flag.
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULO   = 0,
  parameter bit              SATURATE = 1'b0,
  parameter longint unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Top of the count range; MODULO=0 selects the full 2^WIDTH range.
  localparam longint unsigned MAX_L = (MODULO == 0) ? ((64'd1 << WIDTH) - 64'd1)
                                                    : (MODULO - 64'd1);
  // Range-end tests are done one bit wider so that count+STEP cannot alias.
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_L);
  localparam logic [WIDTH:0]   RANGE_X = (WIDTH+1)'(MAX_L + 64'd1);
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX_L);
  localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_sum_x;
  logic [WIDTH:0]   w_load_x;
  logic             w_up_cross;
  logic             w_dn_cross;
  logic [WIDTH-1:0] w_up_wrap;
  logic [WIDTH-1:0] w_dn_diff;
  logic [WIDTH-1:0] w_dn_wrap;
  logic [WIDTH-1:0] w_load_clamp;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;

  assign w_cnt_x      = {1'b0, r_count};
  assign w_sum_x      = w_cnt_x + STEP_X;
  assign w_load_x     = {1'b0, load_val};
  assign w_up_cross   = (w_sum_x > MAX_X);
  assign w_dn_cross   = (w_cnt_x < STEP_X);
  assign w_up_wrap    = WIDTH'(w_sum_x - RANGE_X);
  assign w_dn_diff    = r_count - STEP_N;
  assign w_dn_wrap    = WIDTH'(w_cnt_x + RANGE_X - STEP_X);
  assign w_load_clamp = (w_load_x > MAX_X) ? MAX_N : load_val;

  // Next-state selection: clr beats load beats a counting step beats hold.
  always_comb begin
    w_cnt_nxt  = r_count;
    w_wrap_nxt = 1'b0;
    w_ovf_nxt  = r_ovf;
    if (clr) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (load) begin
      w_cnt_nxt = w_load_clamp;
    end else if (en) begin
      if (up) begin
        if (w_up_cross) begin
          w_cnt_nxt  = SATURATE ? MAX_N : w_up_wrap;
          w_wrap_nxt = 1'b1;
          w_ovf_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_sum_x[WIDTH-1:0];
        end
      end else begin
        if (w_dn_cross) begin
          w_cnt_nxt  = SATURATE ? '0 : w_dn_wrap;
          w_wrap_nxt = 1'b1;
          w_ovf_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_dn_diff;
        end
      end
    end
  end

  // State register; reset takes effect immediately, without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Terminal count flags the step that is about to cross a range end.
  assign tc    = en & ~clr & ~load & (up ? w_up_cross : w_dn_cross);
  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations side by side,
// checked every cycle against an arithmetic model of the counting rules.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en_i = '0, up_i = '0, clr_i = '0, load_i = '0;
  logic [3:0] lv_a = '0, lv_b = '0;
  logic [7:0] lv_c = '0;
  logic [3:0] cnt_a, cnt_b;
  logic [7:0] cnt_c;
  logic [2:0] tc_o, wrap_o, ovf_o;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // A: WIDTH=4 MODULO=10 STEP=1 wrap
  mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .STEP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_i[0]), .up(up_i[0]), .clr(clr_i[0]),
    .load(load_i[0]), .load_val(lv_a), .count(cnt_a), .tc(tc_o[0]),
    .wrap(wrap_o[0]), .ovf(ovf_o[0]));
  // B: WIDTH=4 MODULO=10 STEP=4 saturate
  mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .STEP(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_i[1]), .up(up_i[1]), .clr(clr_i[1]),
    .load(load_i[1]), .load_val(lv_b), .count(cnt_b), .tc(tc_o[1]),
    .wrap(wrap_o[1]), .ovf(ovf_o[1]));
  // C: WIDTH=8 full range STEP=1 wrap
  mod_updown_counter #(.WIDTH(8), .MODULO(0), .SATURATE(1'b0), .STEP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_i[2]), .up(up_i[2]), .clr(clr_i[2]),
    .load(load_i[2]), .load_val(lv_c), .count(cnt_c), .tc(tc_o[2]),
    .wrap(wrap_o[2]), .ovf(ovf_o[2]));

  typedef struct packed {
    int c;
    bit w;
    bit o;
  } mstate_t;

  mstate_t m_st [3] = '{'{0, 1'b0, 1'b0}, '{0, 1'b0, 1'b0}, '{0, 1'b0, 1'b0}};

  function automatic int mmax(input int i);
    return (i == 2) ? 255 : 9;
  endfunction
  function automatic int mstep(input int i);
    return (i == 1) ? 4 : 1;
  endfunction
  function automatic bit msat(input int i);
    return (i == 1);
  endfunction
  function automatic int lv_of(input int i);
    return (i == 0) ? int'(lv_a) : (i == 1) ? int'(lv_b) : int'(lv_c);
  endfunction
  function automatic int dut_cnt(input int i);
    return (i == 0) ? int'(cnt_a) : (i == 1) ? int'(cnt_b) : int'(cnt_c);
  endfunction

  // Counting rules in plain integer arithmetic.
  function automatic mstate_t model_next(input int i, input mstate_t s);
    mstate_t n;
    int mx, st, lv;
    mx = mmax(i);
    st = mstep(i);
    lv = lv_of(i);
    n = '{s.c, 1'b0, s.o};
    if (clr_i[i]) begin
      n = '{0, 1'b0, 1'b0};
    end else if (load_i[i]) begin
      n.c = (lv > mx) ? mx : lv;
    end else if (en_i[i]) begin
      if (up_i[i]) begin
        if (s.c + st <= mx) n.c = s.c + st;
        else begin
          n.c = msat(i) ? mx : s.c + st - (mx + 1);
          n.w = 1'b1;
          n.o = 1'b1;
        end
      end else begin
        if (s.c >= st) n.c = s.c - st;
        else begin
          n.c = msat(i) ? 0 : s.c + (mx + 1) - st;
          n.w = 1'b1;
          n.o = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic int model_tc(input int i);
    if (!en_i[i] || clr_i[i] || load_i[i]) return 0;
    if (up_i[i]) return (m_st[i].c + mstep(i) > mmax(i)) ? 1 : 0;
    return (m_st[i].c < mstep(i)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_st[i] <= '{0, 1'b0, 1'b0};
    end else begin
      for (int i = 0; i < 3; i++) m_st[i] <= model_next(i, m_st[i]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // One clock cycle: check tc before the edge, registered outputs after it.
  task automatic tick();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("tc[%0d]", i), int'(tc_o[i]), model_tc(i));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count[%0d]", i), dut_cnt(i), m_st[i].c);
      chk($sformatf("wrap[%0d]", i), int'(wrap_o[i]), int'(m_st[i].w));
      chk($sformatf("ovf[%0d]", i), int'(ovf_o[i]), int'(m_st[i].o));
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_cnt_c", int'(cnt_c), 0);
    chk("rst_wrap", int'(wrap_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    rst_n = 1'b1;

    // 1: A counts up 12 cycles, wraps 9 -> 0
    en_i[0] = 1'b1; up_i[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 9) chk("lit_tc_at9", int'(tc_o[0]), 1);
      tick();
      if (k == 9) begin
        chk("lit_wrap_cnt0", int'(cnt_a), 0);
        chk("lit_wrap_pulse", int'(wrap_o[0]), 1);
      end
    end
    chk("lit_up12_cnt", int'(cnt_a), 2);
    chk("lit_up12_ovf", int'(ovf_o[0]), 1);
    chk("lit_up12_wrap", int'(wrap_o[0]), 0);

    // 2: A load 3, count down 5, then clear
    en_i[0] = 1'b0; load_i[0] = 1'b1; lv_a = 4'd3;
    tick();
    chk("lit_load3", int'(cnt_a), 3);
    load_i[0] = 1'b0; en_i[0] = 1'b1; up_i[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("lit_down_cnt", int'(cnt_a), 8);
    en_i[0] = 1'b0; clr_i[0] = 1'b1;
    tick();
    chk("lit_clr_cnt", int'(cnt_a), 0);
    chk("lit_clr_ovf", int'(ovf_o[0]), 0);
    clr_i[0] = 1'b0;

    // 3: B saturating up by 4: 4, 8, 9, 9
    en_i[1] = 1'b1; up_i[1] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("lit_sat_cnt", int'(cnt_b), 9);
    chk("lit_sat_wrap", int'(wrap_o[1]), 1);

    // 4: B load clamp, load vs en, clr vs load, saturating down at 0
    en_i[1] = 1'b0; load_i[1] = 1'b1; lv_b = 4'd15;
    tick();
    chk("lit_load_clamp", int'(cnt_b), 9);
    lv_b = 4'd2; en_i[1] = 1'b1;
    tick();
    chk("lit_load_over_en", int'(cnt_b), 2);
    en_i[1] = 1'b0; clr_i[1] = 1'b1; lv_b = 4'd5;
    tick();
    chk("lit_clr_over_load", int'(cnt_b), 0);
    clr_i[1] = 1'b0; load_i[1] = 1'b0; en_i[1] = 1'b1; up_i[1] = 1'b0;
    tick();
    chk("lit_sat_down0", int'(cnt_b), 0);
    chk("lit_sat_down_ovf", int'(ovf_o[1]), 1);
    en_i[1] = 1'b0;

    // 5: C full-range wrap at 255
    en_i[2] = 1'b1; up_i[2] = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    chk("lit_c255", int'(cnt_c), 255);
    tick();
    chk("lit_c_wrap0", int'(cnt_c), 0);
    chk("lit_c_wrap", int'(wrap_o[2]), 1);
    en_i[2] = 1'b0;
    tick();
    chk("lit_c_hold", int'(cnt_c), 0);
    chk("lit_c_hold_wrap", int'(wrap_o[2]), 0);
    en_i[2] = 1'b1; up_i[2] = 1'b0;
    tick();
    chk("lit_c_down_wrap", int'(cnt_c), 255);
    en_i[2] = 1'b0;

    // 6: A to count=6 with ovf set, then asynchronous reset mid-cycle
    load_i[0] = 1'b1; lv_a = 4'd9;
    tick();
    load_i[0] = 1'b0; en_i[0] = 1'b1; up_i[0] = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("lit_pre_rst_cnt", int'(cnt_a), 6);
    chk("lit_pre_rst_ovf", int'(ovf_o[0]), 1);
    en_i[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_cnt", int'(cnt_a), 0);
    chk("lit_async_ovf", int'(ovf_o[0]), 0);
    chk("lit_async_c", int'(cnt_c), 0);
    #2 rst_n = 1'b1;
    en_i[0] = 1'b1; up_i[0] = 1'b1;
    tick();
    chk("lit_post_rst", int'(cnt_a), 1);
    en_i[0] = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised up/down counter with modulo wrap or saturation, synchronous load and clear, a terminal-count indication and a sticky overflow flag. It generalises the team's 8-bit enable-only increment counter. Intended uses are timers, divide-by-N strobes and credit/occupancy tracking in generated designs. Single clock domain; all state is held in registers with reset value 0.

Parameters:
WIDTH, 8, counter width in bits (1..32).
MODULO, 0, count range 0..MODULO-1; 0 means full range 0..2^WIDTH-1. Must satisfy MODULO <= 2^WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.
STEP, 1, increment/decrement magnitude (1..MODULO-1, or 1..2^WIDTH-1 when MODULO=0).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  count enable.
up  input  1  direction: 1 = up, 0 = down; sampled only when counting.
clr  input  1  synchronous clear to 0.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  value to load.
count  output  WIDTH  current registered count.
tc  output  1  combinational: en & counting-direction step would cross the range end.
wrap  output  1  registered one-cycle pulse: the previous edge wrapped or saturated.
ovf  output  1  sticky: set on any wrap or saturation event, cleared by clr or reset.

Behaviour:
- Reset: rst_n low forces count=0, wrap=0, ovf=0 immediately, without waiting for a clock edge. Release is synchronised by the integrator.
- Let MAX = MODULO-1, or 2^WIDTH-1 when MODULO=0. All arithmetic is done in WIDTH+1 bits to detect crossing.
- Priority per edge: clr > load > en > hold.
- clr=1: count<=0, ovf<=0, wrap<=0.
- load=1 (clr=0): count <= min(load_val, MAX); wrap<=0; ovf unchanged.
- en=1, up=1:
  - If count+STEP <= MAX: count <= count+STEP.
  - Otherwise, if SATURATE=0: count <= count+STEP-(MAX+1). If SATURATE=1: count <= MAX.
  - In either overflow case: wrap<=1, ovf<=1.
- en=1, up=0:
  - If count >= STEP: count <= count-STEP.
  - Otherwise, if SATURATE=0: count <= count+(MAX+1)-STEP. If SATURATE=1: count <= 0.
  - In either underflow case: wrap<=1, ovf<=1.
- Saturation when already at the end (e.g. count=MAX, up, SATURATE=1) still counts as an event: wrap=1 and ovf=1.
- en=0, no clr/load: count holds; wrap<=0.
- tc = en & ~clr & ~load & (up ? count+STEP>MAX : count<STEP). It asserts in the same cycle as the crossing edge and is purely combinational from inputs and count.
- Latency: count reflects an operation one edge after it is sampled. wrap lags tc by exactly one cycle.
- Simultaneous clr and load: clr wins and load_val is ignored. Simultaneous load and en: load wins and no step is applied.
- Reset asserted mid-count aborts immediately. The first edge after release acts on the inputs present at that edge.
- When MODULO=0 and SATURATE=0, wrap arithmetic is natural modulo-2^WIDTH.

Test Plan:
1. WIDTH=4, MODULO=10, STEP=1, SATURATE=0. en=1, up=1 for 12 cycles from reset -> count 1..9, 0, 1, 2. tc high only while count=9. wrap pulses the cycle count=0. ovf=1 thereafter.
2. Same configuration. Load load_val=3, then en=1, up=0 for 5 cycles -> count 3, 2, 1, 0, 9, 8. tc high at count=0. wrap pulse at 9. Then clr -> count=0, ovf=0.
3. SATURATE=1, MODULO=10, STEP=4. Counting up from 0 -> 4, 8, 9, 9. wrap=1 on the edges producing 9 from 8 and 9 from 9.
4. load_val=15 with MODULO=10 -> count=9. Assert load and en together -> load wins. Assert clr and load together -> count=0.
5. WIDTH=8, MODULO=0, STEP=1. Count up to 255, then one more step -> count=0, wrap=1. With en=0 -> count holds and wrap=0.
6. With count=6 and ovf=1, drop rst_n between clock edges -> count=0 and ovf=0 immediately. After release, the first en edge gives count=1.
